// File: rtl/trackball_pkg.sv
// Shared constants and types for the trackball step-counter receive path.
package trackball_pkg;

    localparam int CNT_W_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef struct packed {
        logic                 dir;
        logic [CNT_W_DEF-1:0] cnt;
    } tb_axis_t;

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: input synchronisers, armed rising-edge detect,
// wrapping up/down counter and the direction of the last counted step.
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_clk,
    input  logic             step_dir,
    input  logic             armed,
    input  logic             edir,
    output logic             sync_dir,
    output logic [CNT_W-1:0] cnt,
    output logic             dir,
    output logic             step
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] dir_sync_r;
    logic                   prev_clk_r;
    logic                   edge_r;
    logic                   edge_dir_r;
    logic                   step_r;
    logic                   dir_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   edge_s;
    logic [CNT_W-1:0]       next_cnt_s;

    // Rising edge of the synchronised step clock, gated while disarmed.
    always_comb begin
        edge_s = armed & clk_sync_r[SYNC_STAGES-1] & ~prev_clk_r;
    end

    // Next count value for a detected step; wraps modulo 2^CNT_W.
    always_comb begin
        next_cnt_s = cnt_r;
        if (edge_dir_r) begin
            next_cnt_s = cnt_r + ONE;
        end else begin
            next_cnt_s = cnt_r - ONE;
        end
    end

    // Synchroniser chains and previous-level tracking (tracks even when disarmed).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_r <= '0;
            dir_sync_r <= '0;
            prev_clk_r <= 1'b0;
        end else begin
            clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], step_clk};
            dir_sync_r <= {dir_sync_r[SYNC_STAGES-2:0], step_dir};
            prev_clk_r <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    // Edge capture with its effective direction, then counter/dir/pulse update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_r     <= 1'b0;
            edge_dir_r <= 1'b0;
            step_r     <= 1'b0;
            dir_r      <= 1'b0;
            cnt_r      <= '0;
        end else begin
            edge_r     <= edge_s;
            edge_dir_r <= edir;
            step_r     <= edge_r;
            if (edge_r) begin
                cnt_r <= next_cnt_s;
                dir_r <= edge_dir_r;
            end
        end
    end

    assign sync_dir = dir_sync_r[SYNC_STAGES-1];
    assign cnt      = cnt_r;
    assign dir      = dir_r;
    assign step     = step_r;

endmodule

// File: rtl/trackball_counter.sv
// Trackball receive decoder: two axis counters, post-reset arming window,
// cocktail flip and a CPU-read snapshot that only changes on rd_strobe.
module trackball_counter
    import trackball_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             h_clk,
    input  logic             h_dir,
    input  logic             v_clk,
    input  logic             v_dir,
    input  logic             flip,
    input  logic             rd_strobe,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic             h_dir_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             v_dir_o,
    output logic [1:0]       step_o
);

    localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);

    logic [ARM_W-1:0] arm_cnt_r;
    logic             armed_s;
    logic             h_sync_dir_s, v_sync_dir_s;
    logic             h_edir_s, v_edir_s;
    logic [CNT_W-1:0] h_live_cnt_s, v_live_cnt_s;
    logic             h_live_dir_s, v_live_dir_s;
    logic             h_step_s, v_step_s;
    logic [CNT_W-1:0] h_cnt_r, v_cnt_r;
    logic             h_dir_r, v_dir_r;

    // Arming status and flip-adjusted directions for both axes.
    always_comb begin
        armed_s  = (arm_cnt_r == ARM_DONE);
        h_edir_s = h_sync_dir_s ^ flip;
        v_edir_s = v_sync_dir_s ^ flip;
    end

    // Arm counter: saturates once the synchronisers hold post-reset levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_cnt_r <= '0;
        end else if (!armed_s) begin
            arm_cnt_r <= arm_cnt_r + ARM_ONE;
        end
    end

    trackball_axis #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_h_axis (
        .clk      (clk),
        .reset    (reset),
        .step_clk (h_clk),
        .step_dir (h_dir),
        .armed    (armed_s),
        .edir     (h_edir_s),
        .sync_dir (h_sync_dir_s),
        .cnt      (h_live_cnt_s),
        .dir      (h_live_dir_s),
        .step     (h_step_s)
    );

    trackball_axis #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_v_axis (
        .clk      (clk),
        .reset    (reset),
        .step_clk (v_clk),
        .step_dir (v_dir),
        .armed    (armed_s),
        .edir     (v_edir_s),
        .sync_dir (v_sync_dir_s),
        .cnt      (v_live_cnt_s),
        .dir      (v_live_dir_s),
        .step     (v_step_s)
    );

    // Snapshot registers; a simultaneous step lands in the live count, not here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_r <= '0;
            h_dir_r <= 1'b0;
            v_cnt_r <= '0;
            v_dir_r <= 1'b0;
        end else if (rd_strobe) begin
            h_cnt_r <= h_live_cnt_s;
            h_dir_r <= h_live_dir_s;
            v_cnt_r <= v_live_cnt_s;
            v_dir_r <= v_live_dir_s;
        end
    end

    assign h_cnt_o = h_cnt_r;
    assign h_dir_o = h_dir_r;
    assign v_cnt_o = v_cnt_r;
    assign v_dir_o = v_dir_r;
    assign step_o  = {v_step_s, h_step_s};

endmodule
